// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read bus and fetch-to-decode handshake shared by the
// fetch stage (master) and its memory/decode neighbours (slave).
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid,
    output imem_ack, imem_rdata, inst_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues one memory read per PC, hands the word to
// decode, pulses pc_advance once per fetched word, traps timeout/misalignment.
module if_fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_flush,
  if_fetch_unit_if.master   bus,
  output logic              o_pc_advance,
  output logic [1:0]        o_fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            r_state, w_state;
  logic              r_req, w_req;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_inst, w_inst;
  logic [ADDR_W-1:0] r_inst_pc, w_inst_pc;
  logic              r_valid, w_valid;
  logic              r_adv, w_adv;
  logic [1:0]        r_err, w_err;
  logic [CNT_W-1:0]  r_cnt, w_cnt;

  // State and every output register; outputs are driven only from here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
      r_adv     <= 1'b0;
      r_err     <= 2'b00;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state;
      r_req     <= w_req;
      r_addr    <= w_addr;
      r_inst    <= w_inst;
      r_inst_pc <= w_inst_pc;
      r_valid   <= w_valid;
      r_adv     <= w_adv;
      r_err     <= w_err;
      r_cnt     <= w_cnt;
    end
  end

  // Next-state and next-output decode; pc_advance defaults low so it can
  // only ever be a single-cycle pulse on entry to HOLD.
  always_comb begin
    w_state   = r_state;
    w_req     = r_req;
    w_addr    = r_addr;
    w_inst    = r_inst;
    w_inst_pc = r_inst_pc;
    w_valid   = r_valid;
    w_adv     = 1'b0;
    w_err     = r_err;
    w_cnt     = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_flush) begin
          w_state = S_IDLE;
        end else if (i_pc[1:0] != 2'b00) begin
          w_state = S_ERR;
          w_req   = 1'b0;
          w_err   = 2'b10;
        end else begin
          w_state = S_REQ;
          w_req   = 1'b1;
          w_addr  = i_pc;
          w_cnt   = '0;
        end
      end
      S_REQ: begin
        if (bus.imem_ack) begin
          w_req = 1'b0;
          if (i_flush) begin
            w_state = S_IDLE;
          end else begin
            w_state   = S_HOLD;
            w_inst    = bus.imem_rdata;
            w_inst_pc = r_addr;
            w_valid   = 1'b1;
            w_adv     = 1'b1;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state = S_ERR;
          w_req   = 1'b0;
          w_err   = 2'b01;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
          // A redirect without ack must still wait out the in-flight read.
          if (i_flush) begin
            w_state = S_DRAIN;
          end else begin
            w_state = S_REQ;
          end
        end
      end
      S_DRAIN: begin
        if (bus.imem_ack) begin
          w_state = S_IDLE;
          w_req   = 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          w_state = S_ERR;
          w_req   = 1'b0;
          w_err   = 2'b01;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (i_flush || (r_valid && bus.inst_ready)) begin
          w_state = S_IDLE;
          w_valid = 1'b0;
        end else begin
          w_state = S_HOLD;
        end
      end
      S_ERR: begin
        w_state = S_ERR;
        w_req   = 1'b0;
        w_valid = 1'b0;
      end
      default: begin
        w_state = S_IDLE;
        w_req   = 1'b0;
        w_valid = 1'b0;
      end
    endcase
  end

  assign bus.imem_req   = r_req;
  assign bus.imem_addr  = r_addr;
  assign bus.inst       = r_inst;
  assign bus.inst_pc    = r_inst_pc;
  assign bus.inst_valid = r_valid;
  assign o_pc_advance   = r_adv;
  assign o_fetch_err    = r_err;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: fetch, backpressure, flushes, async
// reset, timeout and misalignment traps, with hand-computed expectations.
module tb_if_fetch_unit;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic              pc_advance;
  logic [1:0]        fetch_err;
  int                checks;
  int                errors;

  if_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  if_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_pc         (pc),
    .i_flush      (flush),
    .bus          (bus),
    .o_pc_advance (pc_advance),
    .o_fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    pc = 32'h0;
    flush = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.inst_ready = 1'b0;
    step();
    step();
    chk("rst_req",   {31'd0, bus.imem_req},   32'd0);
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_adv",   {31'd0, pc_advance},     32'd0);
    chk("rst_addr",  bus.imem_addr,           32'h0);
    chk("rst_inst",  bus.inst,                32'h0);
    chk("rst_ipc",   bus.inst_pc,             32'h0);
    chk("rst_err",   {30'd0, fetch_err},      32'd0);

    // Basic fetch: ack on the second request cycle
    reset_n = 1'b1;
    step();
    chk("b_req1", {31'd0, bus.imem_req}, 32'd1);
    chk("b_addr", bus.imem_addr, 32'h0);
    step();
    chk("b_req2", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h2008_0005;
    step();
    bus.imem_ack = 1'b0;
    chk("b_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("b_adv",   {31'd0, pc_advance},     32'd1);
    chk("b_req0",  {31'd0, bus.imem_req},   32'd0);
    chk("b_inst",  bus.inst,    32'h2008_0005);
    chk("b_ipc",   bus.inst_pc, 32'h0);
    bus.inst_ready = 1'b1;
    step();
    pc = 32'h4;
    bus.inst_ready = 1'b0;
    chk("b_valid0", {31'd0, bus.inst_valid}, 32'd0);
    chk("b_adv0",   {31'd0, pc_advance},     32'd0);
    chk("b_idle_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    chk("b_next_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("b_next_addr", bus.imem_addr, 32'h4);

    // Backpressure: zero-wait ack, decode stalls five cycles
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h8C09_0010;
    step();
    bus.imem_ack = 1'b0;
    chk("bp_adv",  {31'd0, pc_advance}, 32'd1);
    chk("bp_inst", bus.inst, 32'h8C09_0010);
    chk("bp_ipc",  bus.inst_pc, 32'h4);
    for (int i = 0; i < 5; i++) begin
      step();
      pc = 32'h8;
      chk("bp_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("bp_stable", bus.inst, 32'h8C09_0010);
      chk("bp_adv0", {31'd0, pc_advance}, 32'd0);
      chk("bp_noreq", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    chk("bp_valid0", {31'd0, bus.inst_valid}, 32'd0);
    step();
    chk("bp_next_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("bp_next_addr", bus.imem_addr, 32'h8);

    // Flush in REQ two cycles before ack; PC redirected to 0x40
    flush = 1'b1;
    step();
    flush = 1'b0;
    pc = 32'h40;
    chk("fr_drain_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("fr_drain_addr", bus.imem_addr, 32'h8);
    step();
    chk("fr_drain_req2", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_ack = 1'b0;
    chk("fr_req0",  {31'd0, bus.imem_req},   32'd0);
    chk("fr_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("fr_adv",   {31'd0, pc_advance},     32'd0);
    chk("fr_inst",  bus.inst, 32'h8C09_0010);
    step();
    chk("fr_next_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("fr_next_addr", bus.imem_addr, 32'h40);

    // Flush and handshake in the same HOLD cycle; target 0x80
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0000_0013;
    step();
    bus.imem_ack = 1'b0;
    chk("fh_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("fh_ipc",   bus.inst_pc, 32'h40);
    flush = 1'b1;
    bus.inst_ready = 1'b1;
    step();
    flush = 1'b0;
    bus.inst_ready = 1'b0;
    pc = 32'h80;
    chk("fh_valid0", {31'd0, bus.inst_valid}, 32'd0);
    chk("fh_adv0",   {31'd0, pc_advance},     32'd0);
    step();
    chk("fh_next_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("fh_next_addr", bus.imem_addr, 32'h80);

    // Asynchronous reset in the middle of REQ
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_req",  {31'd0, bus.imem_req}, 32'd0);
    chk("ar_addr", bus.imem_addr, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    chk("ar_restart_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("ar_restart_addr", bus.imem_addr, 32'h80);

    // Timeout: no ack, request held exactly TIMEOUT cycles
    step();
    chk("to_req2", {31'd0, bus.imem_req}, 32'd1);
    step();
    chk("to_req3", {31'd0, bus.imem_req}, 32'd1);
    step();
    chk("to_req4", {31'd0, bus.imem_req}, 32'd1);
    chk("to_err_pending", {30'd0, fetch_err}, 32'd0);
    step();
    chk("to_req_drop", {31'd0, bus.imem_req}, 32'd0);
    chk("to_err", {30'd0, fetch_err}, 32'd1);
    flush = 1'b1;
    bus.imem_ack = 1'b1;
    step();
    flush = 1'b0;
    bus.imem_ack = 1'b0;
    step();
    chk("to_err_held", {30'd0, fetch_err}, 32'd1);
    chk("to_req_held", {31'd0, bus.imem_req}, 32'd0);
    chk("to_valid",    {31'd0, bus.inst_valid}, 32'd0);
    chk("to_adv",      {31'd0, pc_advance}, 32'd0);

    // Misaligned PC: trap without issuing a request
    reset_n = 1'b0;
    pc = 32'h6;
    #1;
    chk("ma_err_clr", {30'd0, fetch_err}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("ma_req",  {31'd0, bus.imem_req}, 32'd0);
    chk("ma_err",  {30'd0, fetch_err}, 32'd2);
    chk("ma_addr", bus.imem_addr, 32'h0);
    step();
    step();
    chk("ma_err_held", {30'd0, fetch_err}, 32'd2);
    chk("ma_req_held", {31'd0, bus.imem_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
